// File: rtl/bp_eaddr_xlate_pkg.sv
// SV39 address-translation constants and the translation entry struct macro
// shared by the eaddr translation stage and its CAM.
`ifndef BP_EADDR_XLATE_PKG_SV
`define BP_EADDR_XLATE_PKG_SV

`define DECLARE_BP_XLATE_ENTRY_S(vtag_w, ptag_w) \
  typedef struct packed {                        \
    logic              v;                        \
    logic [vtag_w-1:0] vtag;                     \
    logic [ptag_w-1:0] ptag;                     \
  } bp_xlate_entry_s;

package bp_eaddr_xlate_pkg;

  localparam int unsigned sv39_eaddr_width_gp       = 64;
  localparam int unsigned sv39_vaddr_width_gp       = 39;
  localparam int unsigned sv39_paddr_width_gp       = 56;
  localparam int unsigned sv39_page_offset_width_gp = 12;

  // Upper eaddr bits that must be a sign extension of the top vaddr bit.
  localparam int unsigned sv39_canon_lsb_gp   = sv39_vaddr_width_gp - 1;
  localparam int unsigned sv39_canon_width_gp = sv39_eaddr_width_gp - sv39_canon_lsb_gp;

endpackage

`endif

// File: rtl/bp_eaddr_xlate_if.sv
// Request, fill, flush and result bundle of the eaddr translation stage.
interface bp_eaddr_xlate_if
  import bp_eaddr_xlate_pkg::*;
#(
  parameter int unsigned eaddr_width_p       = sv39_eaddr_width_gp,
  parameter int unsigned vaddr_width_p       = sv39_vaddr_width_gp,
  parameter int unsigned paddr_width_p       = sv39_paddr_width_gp,
  parameter int unsigned page_offset_width_p = sv39_page_offset_width_gp
);
  localparam int unsigned vtag_width_lp = vaddr_width_p - page_offset_width_p;
  localparam int unsigned ptag_width_lp = paddr_width_p - page_offset_width_p;

  logic                     translation_en_i;
  logic                     v_i;
  logic                     ready_o;
  logic [eaddr_width_p-1:0] eaddr_i;

  logic                     w_v_i;
  logic [vtag_width_lp-1:0] w_vtag_i;
  logic [ptag_width_lp-1:0] w_ptag_i;
  logic                     flush_i;

  logic                     r_v_o;
  logic                     r_yumi_i;
  logic [paddr_width_p-1:0] r_paddr_o;
  logic                     r_miss_o;
  logic                     r_page_fault_o;
  logic                     r_access_fault_o;

  modport master (
    output translation_en_i, v_i, eaddr_i, w_v_i, w_vtag_i, w_ptag_i, flush_i, r_yumi_i,
    input  ready_o, r_v_o, r_paddr_o, r_miss_o, r_page_fault_o, r_access_fault_o
  );

  modport slave (
    input  translation_en_i, v_i, eaddr_i, w_v_i, w_vtag_i, w_ptag_i, flush_i, r_yumi_i,
    output ready_o, r_v_o, r_paddr_o, r_miss_o, r_page_fault_o, r_access_fault_o
  );

endinterface

// File: rtl/bp_eaddr_xlate_cam.sv
// Fully-associative translation buffer: entry storage, lookup match,
// fill victim selection and round-robin replacement pointer.
module bp_xlate_cam
  import bp_eaddr_xlate_pkg::*;
#(
  parameter int unsigned vtag_width_p = 27,
  parameter int unsigned ptag_width_p = 44,
  parameter int unsigned els_p        = 8
)
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic                    w_v_i,
  input  logic [vtag_width_p-1:0] w_vtag_i,
  input  logic [ptag_width_p-1:0] w_ptag_i,
  input  logic [vtag_width_p-1:0] r_vtag_i,
  output logic                    r_hit_o,
  output logic [ptag_width_p-1:0] r_ptag_o
);
  localparam int unsigned ptr_width_lp = $clog2(els_p);

  `DECLARE_BP_XLATE_ENTRY_S(vtag_width_p, ptag_width_p)

  bp_xlate_entry_s         entry_q [els_p];
  logic [ptr_width_lp-1:0] ptr_q;
  logic [els_p-1:0]        hit_v;

  logic                    w_match;
  logic [ptr_width_lp-1:0] w_match_idx;
  logic                    inv_found;
  logic [ptr_width_lp-1:0] inv_idx;
  logic [ptr_width_lp-1:0] victim;
  logic                    use_ptr;

  always_comb begin
    hit_v    = '0;
    r_ptag_o = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      hit_v[i] = entry_q[i].v && (entry_q[i].vtag == r_vtag_i);
      r_ptag_o = r_ptag_o | ({ptag_width_p{hit_v[i]}} & entry_q[i].ptag);
    end
  end
  assign r_hit_o = |hit_v;

  // Victim priority: matching vtag, then lowest invalid slot, then the pointer.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    inv_found   = 1'b0;
    inv_idx     = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      if (entry_q[i].v && (entry_q[i].vtag == w_vtag_i)) begin
        w_match     = 1'b1;
        w_match_idx = ptr_width_lp'(i);
      end
      if (!entry_q[i].v && !inv_found) begin
        inv_found = 1'b1;
        inv_idx   = ptr_width_lp'(i);
      end
    end
    use_ptr = !w_match && !inv_found;
    victim  = w_match ? w_match_idx : (inv_found ? inv_idx : ptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < els_p; i++) entry_q[i].v <= 1'b0;
      ptr_q <= '0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < els_p; i++) entry_q[i].v <= 1'b0;
    end else if (w_v_i) begin
      entry_q[victim].v    <= 1'b1;
      entry_q[victim].vtag <= w_vtag_i;
      entry_q[victim].ptag <= w_ptag_i;
      if (use_ptr)
        ptr_q <= (ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  a_hit_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(hit_v));

endmodule

// File: rtl/bp_eaddr_xlate.sv
// Effective-to-physical address translation stage: canonicality check,
// bare passthrough, translation buffer lookup and a valid/yumi output register.
module bp_eaddr_xlate
  import bp_eaddr_xlate_pkg::*;
#(
  parameter int unsigned eaddr_width_p       = sv39_eaddr_width_gp,
  parameter int unsigned vaddr_width_p       = sv39_vaddr_width_gp,
  parameter int unsigned paddr_width_p       = sv39_paddr_width_gp,
  parameter int unsigned page_offset_width_p = sv39_page_offset_width_gp,
  parameter int unsigned els_p               = 8
)
(
  input logic           clk_i,
  input logic           reset_i,
  bp_eaddr_xlate_if.slave io
);
  localparam int unsigned vtag_width_lp  = vaddr_width_p - page_offset_width_p;
  localparam int unsigned ptag_width_lp  = paddr_width_p - page_offset_width_p;
  localparam int unsigned canon_width_lp = eaddr_width_p - vaddr_width_p + 1;

  logic [canon_width_lp-1:0] canon_bits;
  logic                      page_fault;
  logic                      access_fault;
  logic [vtag_width_lp-1:0]  lookup_vtag;
  logic                      cam_hit;
  logic [ptag_width_lp-1:0]  cam_ptag;
  logic                      accept;

  logic [paddr_width_p-1:0]  paddr_n;
  logic                      miss_n, page_fault_n, access_fault_n;

  logic                      r_v_q;
  logic [paddr_width_p-1:0]  r_paddr_q;
  logic                      r_miss_q, r_page_fault_q, r_access_fault_q;

  assign canon_bits   = io.eaddr_i[eaddr_width_p-1:vaddr_width_p-1];
  assign page_fault   = !((canon_bits == '0) || (canon_bits == '1));
  assign access_fault = |io.eaddr_i[eaddr_width_p-1:paddr_width_p];
  assign lookup_vtag  = io.eaddr_i[vaddr_width_p-2:page_offset_width_p];

  bp_xlate_cam #(
    .vtag_width_p(vtag_width_lp),
    .ptag_width_p(ptag_width_lp),
    .els_p       (els_p)
  ) cam (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (io.flush_i),
    .w_v_i   (io.w_v_i),
    .w_vtag_i(io.w_vtag_i),
    .w_ptag_i(io.w_ptag_i),
    .r_vtag_i(lookup_vtag),
    .r_hit_o (cam_hit),
    .r_ptag_o(cam_ptag)
  );

  assign io.ready_o = !reset_i && !io.flush_i && (!r_v_q || io.r_yumi_i);
  assign accept     = io.v_i && io.ready_o;

  always_comb begin
    paddr_n        = '0;
    miss_n         = 1'b0;
    page_fault_n   = 1'b0;
    access_fault_n = 1'b0;
    if (io.translation_en_i) begin
      if (page_fault)
        page_fault_n = 1'b1;
      else if (cam_hit)
        paddr_n = {cam_ptag, io.eaddr_i[page_offset_width_p-1:0]};
      else
        miss_n = 1'b1;
    end else begin
      paddr_n        = io.eaddr_i[paddr_width_p-1:0];
      access_fault_n = access_fault;
    end
  end

  // Data fields keep their last value after yumi; only r_v_q drops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v_q            <= 1'b0;
      r_paddr_q        <= '0;
      r_miss_q         <= 1'b0;
      r_page_fault_q   <= 1'b0;
      r_access_fault_q <= 1'b0;
    end else if (accept) begin
      r_v_q            <= 1'b1;
      r_paddr_q        <= paddr_n;
      r_miss_q         <= miss_n;
      r_page_fault_q   <= page_fault_n;
      r_access_fault_q <= access_fault_n;
    end else if (io.r_yumi_i) begin
      r_v_q <= 1'b0;
    end
  end

  assign io.r_v_o            = r_v_q;
  assign io.r_paddr_o        = r_paddr_q;
  assign io.r_miss_o         = r_miss_q;
  assign io.r_page_fault_o   = r_page_fault_q;
  assign io.r_access_fault_o = r_access_fault_q;

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i) io.r_yumi_i |-> r_v_q);

endmodule

// File: tb/tb_bp_eaddr_xlate.sv
// Directed bench for bp_eaddr_xlate: vector table plus hand-written
// backpressure, flush, same-cycle fill and reset sequences.
module tb_bp_eaddr_xlate;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_eaddr_xlate_if #(
    .eaddr_width_p(64), .vaddr_width_p(39), .paddr_width_p(56), .page_offset_width_p(12)
  ) bus ();

  bp_eaddr_xlate #(
    .eaddr_width_p(64), .vaddr_width_p(39), .paddr_width_p(56),
    .page_offset_width_p(12), .els_p(8)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .io     (bus)
  );

  typedef enum int {OP_LOOKUP, OP_FILL, OP_FLUSH} op_e;
  typedef struct {
    op_e         op;
    string       name;
    logic        en;
    logic [63:0] eaddr;
    logic [26:0] vtag;
    logic [43:0] ptag;
    logic [55:0] exp_paddr;
    logic        exp_miss;
    logic        exp_pf;
    logic        exp_af;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_lk(input string n, input logic en, input logic [63:0] ea,
                                 input logic [55:0] p, input logic m, input logic pf,
                                 input logic af);
    vec_t v;
    v.op = OP_LOOKUP; v.name = n; v.en = en; v.eaddr = ea; v.vtag = '0; v.ptag = '0;
    v.exp_paddr = p; v.exp_miss = m; v.exp_pf = pf; v.exp_af = af;
    vecs.push_back(v);
  endfunction

  function automatic void add_op(input op_e op, input string n, input logic [26:0] vt,
                                 input logic [43:0] pt);
    vec_t v;
    v.op = op; v.name = n; v.en = 1'b0; v.eaddr = '0; v.vtag = vt; v.ptag = pt;
    v.exp_paddr = '0; v.exp_miss = 1'b0; v.exp_pf = 1'b0; v.exp_af = 1'b0;
    vecs.push_back(v);
  endfunction

  function automatic logic [63:0] ea_of(input logic [26:0] vt);
    return (64'(vt) << 12) | 64'hABC;
  endfunction

  function automatic logic [55:0] pa_of(input logic [43:0] pt);
    return (56'(pt) << 12) | 56'hABC;
  endfunction

  task automatic do_fill(input logic [26:0] vt, input logic [43:0] pt);
    bus.w_v_i = 1'b1; bus.w_vtag_i = vt; bus.w_ptag_i = pt;
    step();
    bus.w_v_i = 1'b0;
  endtask

  task automatic do_flush(input string n);
    bus.flush_i = 1'b1;
    #1 chk({n, "_ready_low"}, 64'(bus.ready_o), 64'd0);
    step();
    bus.flush_i = 1'b0;
  endtask

  task automatic check_result(input string n, input logic [55:0] p, input logic m,
                              input logic pf, input logic af);
    chk({n, "_rv"},    64'(bus.r_v_o), 64'd1);
    chk({n, "_paddr"}, 64'(bus.r_paddr_o), 64'(p));
    chk({n, "_miss"},  64'(bus.r_miss_o), 64'(m));
    chk({n, "_pf"},    64'(bus.r_page_fault_o), 64'(pf));
    chk({n, "_af"},    64'(bus.r_access_fault_o), 64'(af));
  endtask

  task automatic do_lookup(input string n, input logic en, input logic [63:0] ea,
                           input logic [55:0] p, input logic m, input logic pf,
                           input logic af);
    bus.translation_en_i = en; bus.eaddr_i = ea; bus.v_i = 1'b1; bus.r_yumi_i = 1'b0;
    #1 chk({n, "_ready"}, 64'(bus.ready_o), 64'd1);
    step();
    bus.v_i = 1'b0;
    check_result(n, p, m, pf, af);
    bus.r_yumi_i = 1'b1;
    step();
    bus.r_yumi_i = 1'b0;
    chk({n, "_drained"}, 64'(bus.r_v_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] held;

    bus.translation_en_i = 1'b0; bus.v_i = 1'b1; bus.eaddr_i = 64'h10;
    bus.w_v_i = 1'b0; bus.w_vtag_i = '0; bus.w_ptag_i = '0;
    bus.flush_i = 1'b0; bus.r_yumi_i = 1'b0;

    // Vector table
    add_lk("miss0",   1'b1, 64'h0000_0000_0040_1234, 56'h0, 1'b1, 1'b0, 1'b0);
    add_op(OP_FILL,   "fill401", 27'h401, 44'hABC);
    add_lk("hit401",  1'b1, 64'h0000_0000_0040_1234, 56'h00_0000_0ABC_234, 1'b0, 1'b0, 1'b0);
    add_lk("noncanon",1'b1, 64'h0000_0040_0000_0000, 56'h0, 1'b0, 1'b1, 1'b0);
    add_lk("canonneg",1'b1, 64'hFFFF_FFC0_0000_0000, 56'h0, 1'b1, 1'b0, 1'b0);
    add_lk("pt_af",   1'b0, 64'h0100_0000_0000_0010, 56'h10, 1'b0, 1'b0, 1'b1);
    add_lk("pt_ok",   1'b0, 64'h0000_0000_0000_0010, 56'h10, 1'b0, 1'b0, 1'b0);
    add_op(OP_FLUSH,  "flush_a", '0, '0);
    for (int v = 1; v <= 9; v++) add_op(OP_FILL, $sformatf("fill%0d", v), 27'(v), 44'(32'h100 + v));
    add_lk("evicted1", 1'b1, ea_of(27'd1), 56'h0, 1'b1, 1'b0, 1'b0);
    for (int v = 2; v <= 9; v++)
      add_lk($sformatf("hit%0d", v), 1'b1, ea_of(27'(v)), pa_of(44'(32'h100 + v)), 1'b0, 1'b0, 1'b0);
    add_op(OP_FILL,   "refill5", 27'd5, 44'h555);
    add_lk("hit5new",  1'b1, ea_of(27'd5), pa_of(44'h555), 1'b0, 1'b0, 1'b0);
    add_lk("hit6kept", 1'b1, ea_of(27'd6), pa_of(44'h106), 1'b0, 1'b0, 1'b0);
    add_op(OP_FILL,   "fill10", 27'd10, 44'h10A);
    add_lk("evicted2", 1'b1, ea_of(27'd2), 56'h0, 1'b1, 1'b0, 1'b0);
    add_lk("hit10",    1'b1, ea_of(27'd10), pa_of(44'h10A), 1'b0, 1'b0, 1'b0);
    add_lk("hit3",     1'b1, ea_of(27'd3), pa_of(44'h103), 1'b0, 1'b0, 1'b0);

    // Reset state
    step();
    #1 chk("rst_ready", 64'(bus.ready_o), 64'd0);
    step();
    chk("rst_rv", 64'(bus.r_v_o), 64'd0);
    chk("rst_paddr", 64'(bus.r_paddr_o), 64'd0);
    bus.v_i = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_rv", 64'(bus.r_v_o), 64'd0);
    chk("post_rst_paddr", 64'(bus.r_paddr_o), 64'd0);
    chk("post_rst_flags", 64'({bus.r_miss_o, bus.r_page_fault_o, bus.r_access_fault_o}), 64'd0);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_LOOKUP: do_lookup(vecs[i].name, vecs[i].en, vecs[i].eaddr, vecs[i].exp_paddr,
                             vecs[i].exp_miss, vecs[i].exp_pf, vecs[i].exp_af);
        OP_FILL:   do_fill(vecs[i].vtag, vecs[i].ptag);
        default:   do_flush(vecs[i].name);
      endcase
    end

    // Backpressure: hold result three cycles, then stream with yumi every cycle
    bus.translation_en_i = 1'b0; bus.eaddr_i = 64'h20; bus.v_i = 1'b1; bus.r_yumi_i = 1'b0;
    step();
    bus.eaddr_i = 64'h99;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_ready", k), 64'(bus.ready_o), 64'd0);
      chk($sformatf("hold%0d_paddr", k), 64'(bus.r_paddr_o), 64'h20);
      step();
    end
    bus.r_yumi_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.eaddr_i = 64'h30 + 64'(k) * 64'h10;
      #1 chk($sformatf("b2b%0d_ready", k), 64'(bus.ready_o), 64'd1);
      step();
      chk($sformatf("b2b%0d_rv", k), 64'(bus.r_v_o), 64'd1);
      chk($sformatf("b2b%0d_paddr", k), 64'(bus.r_paddr_o), 64'h30 + 64'(k) * 64'h10);
    end
    bus.v_i = 1'b0;
    step();
    bus.r_yumi_i = 1'b0;
    chk("b2b_drained", 64'(bus.r_v_o), 64'd0);

    // Flush with a held hit result and a same-cycle fill
    bus.translation_en_i = 1'b1; bus.eaddr_i = ea_of(27'd3); bus.v_i = 1'b1;
    step();
    bus.v_i = 1'b0;
    held = pa_of(44'h103);
    bus.w_v_i = 1'b1; bus.w_vtag_i = 27'h77; bus.w_ptag_i = 44'h1;
    do_flush("flushfill");
    bus.w_v_i = 1'b0;
    check_result("held_over_flush", held, 1'b0, 1'b0, 1'b0);
    bus.r_yumi_i = 1'b1;
    step();
    bus.r_yumi_i = 1'b0;
    do_lookup("dropped77", 1'b1, ea_of(27'h77), 56'h0, 1'b1, 1'b0, 1'b0);
    do_lookup("flushed3",  1'b1, ea_of(27'd3), 56'h0, 1'b1, 1'b0, 1'b0);

    // Same-cycle fill and lookup of that vtag
    bus.w_v_i = 1'b1; bus.w_vtag_i = 27'h88; bus.w_ptag_i = 44'h22;
    bus.translation_en_i = 1'b1; bus.eaddr_i = 64'h0000_0000_0008_8000; bus.v_i = 1'b1;
    step();
    bus.w_v_i = 1'b0; bus.v_i = 1'b0;
    check_result("fill_lookup_same", 56'h0, 1'b1, 1'b0, 1'b0);
    bus.r_yumi_i = 1'b1;
    step();
    bus.r_yumi_i = 1'b0;
    do_lookup("fill_lookup_next", 1'b1, 64'h0000_0000_0008_8000, 56'h22000, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation discards the held result
    bus.translation_en_i = 1'b0; bus.eaddr_i = 64'h1234; bus.v_i = 1'b1;
    step();
    bus.v_i = 1'b0;
    chk("pre_reset_rv", 64'(bus.r_v_o), 64'd1);
    rst = 1'b1;
    #1 chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    step();
    chk("midrst_rv", 64'(bus.r_v_o), 64'd0);
    chk("midrst_paddr", 64'(bus.r_paddr_o), 64'd0);
    rst = 1'b0;
    step();
    do_lookup("rst_cleared88", 1'b1, 64'h0000_0000_0008_8000, 56'h0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_eaddr_xlate.md
Name: bp_eaddr_xlate

Overview:
Parametrised effective-to-physical address translation stage for the BlackParrot FE/BE memory paths.
- Generalises the fixed eaddr/vaddr/paddr widths to configurable SV39-style widths.
- Adds a canonicality check, a small fully-associative translation buffer with fill and flush, and a registered valid/yumi output stage.
- Sits between effective-address generation and the cache tag lookup. Misses are reported for an external page-table walker, which refills the block through the fill port.

Parameters:
- eaddr_width_p, 64, effective address width.
- vaddr_width_p, 39, virtual address width; bits [eaddr_width_p-1:vaddr_width_p-1] must all be equal.
- paddr_width_p, 56, physical address width.
- page_offset_width_p, 12, untranslated low bits.
- els_p, 8, number of translation entries; must be at least 2.
- Derived, not overridable: vtag_width_lp = vaddr_width_p - page_offset_width_p (27); ptag_width_lp = paddr_width_p - page_offset_width_p (44).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- translation_en_i  in  1  1 = translate through the buffer; 0 = bare passthrough
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- eaddr_i  in  eaddr_width_p  request effective address
- w_v_i  in  1  fill valid; always accepted
- w_vtag_i  in  vtag_width_lp  fill virtual tag
- w_ptag_i  in  ptag_width_lp  fill physical tag
- flush_i  in  1  invalidate all entries
- r_v_o  out  1  result valid
- r_yumi_i  in  1  result consumed; legal only while r_v_o = 1
- r_paddr_o  out  paddr_width_p  translated physical address
- r_miss_o  out  1  translation not present
- r_page_fault_o  out  1  non-canonical effective address
- r_access_fault_o  out  1  passthrough address exceeds the physical range

Behaviour:
- Reset: all entry valid bits clear, replacement pointer = 0, r_v_o = 0. All r_* data outputs are 0 during and after reset until the first accepted request. ready_o = 0 while reset_i = 1.
- Handshake: ready_o = ~r_v_o | r_yumi_i.
  - An accepted request loads the output register at the next clock edge: 1-cycle latency.
  - The output register holds its value stable until yumi. Yumi and a new accept in the same cycle give back-to-back throughput.
- Flush stall: ready_o is also forced to 0 in any cycle with flush_i = 1.
- Translate mode (translation_en_i = 1):
  - Page fault when eaddr_i[eaddr_width_p-1:vaddr_width_p-1] is not all-0 and not all-1. Then page_fault = 1, miss = 0, paddr = 0.
  - Otherwise vtag = eaddr_i[vaddr_width_p-2:page_offset_width_p] is compared against all valid entries.
  - Hit: paddr = {ptag, eaddr_i[page_offset_width_p-1:0]}, miss = 0.
  - No hit: miss = 1, paddr = 0.
  - access_fault = 0 in translate mode.
- Passthrough mode (translation_en_i = 0):
  - paddr = eaddr_i[paddr_width_p-1:0].
  - access_fault = 1 if any eaddr_i[eaddr_width_p-1:paddr_width_p] bit is set.
  - miss = 0, page_fault = 0.
- The mode is sampled with the request and registered alongside it.
- Fill, victim selection in priority order:
  1. An existing valid entry with an equal vtag is overwritten (no duplicates, ever).
  2. Otherwise the lowest-index invalid entry is written.
  3. Otherwise the entry at the replacement pointer is written, and the pointer increments modulo els_p (wraps from els_p-1 to 0).
  - The pointer advances only on case 3.
- Simultaneous events:
  - Lookup and fill in the same cycle: the lookup sees the pre-fill state.
  - Fill and flush in the same cycle: flush wins and the fill is dropped.
  - Flush clears all valid bits at the next edge. It does not reset the pointer and does not disturb a result already held in the output register.
- Reset mid-operation discards any held result (r_v_o = 0 next cycle).
- Illegal stimulus: r_yumi_i = 1 while r_v_o = 0 is illegal; assert in simulation.
- The hit vector is one-hot or zero by construction. Assert this in simulation.

Decomposition:
- bp_common_pkg gains:
  - SV39 constants: vaddr 39, paddr 56, page offset 12.
  - A `declare_bp_xlate_entry_s(vtag, ptag)` struct macro: v, vtag, ptag.
  - The canonicality-check width constants.
- One sub-module, bp_xlate_cam: entry storage, match vector, victim selection and replacement pointer. Ports: clk_i, reset_i, flush_i, w_v_i, w_vtag_i, w_ptag_i, r_vtag_i, r_hit_o, r_ptag_o.
- The top level holds the canonicality check, passthrough logic and output register.

Test Plan:
- Reset, then translation_en_i = 1, eaddr 0x0000_0000_0040_1234 -> miss = 1 one cycle later. Fill vtag 0x401, ptag 0xABC, then repeat the request -> paddr 0x00_0000_0ABC_234, miss = 0.
- Non-canonical eaddr 0x0000_0040_0000_0000 (bit 38 = 1, bit 39 = 0) -> page_fault = 1, paddr = 0. eaddr 0xFFFF_FFC0_0000_0000 -> no page fault (miss).
- translation_en_i = 0, eaddr 0x0100_0000_0000_0010 -> access_fault = 1. eaddr 0x0000_0000_0000_0010 -> paddr 0x10, no faults.
- Fill 9 distinct vtags 1..9 into els_p = 8 -> vtag 1 evicted (pointer 0 -> 1), vtags 2..9 hit. Refill vtag 5 with a new ptag -> no eviction, the new ptag is returned.
- Hold r_yumi_i = 0 for 3 cycles with v_i = 1 -> ready_o = 0 and outputs stable. Then yumi every cycle -> one result per cycle.
- Same-cycle fill + flush -> all subsequent lookups miss. Same-cycle fill + lookup of that vtag -> miss, and the next lookup hits.
